// File: rtl/ddr_ca_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr_ca_delay_ctrl
// Brief    : Sequences LOAD/MOVE/DIRECTION pulses for the DDR4 CA IOD delay
//            lines, keeping a shadow tap count per lane.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_ca_delay_ctrl #(
    parameter int NUM_LANES     = 8,
    parameter int LANE_W        = 3,
    parameter int TAP_W         = 8,
    parameter int MAX_TAP       = 127,
    parameter int LOAD_TAP      = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         FAB_CLK,
    input  logic                         SYNC_RST,
    input  logic                         CMD_VALID,
    output logic                         CMD_READY,
    input  logic [LANE_W-1:0]            CMD_LANE,
    input  logic [1:0]                   CMD_OP,
    input  logic [TAP_W-1:0]             CMD_ARG,
    output logic                         RSP_VALID,
    output logic [1:0]                   RSP_STATUS,
    output logic [TAP_W-1:0]             RSP_TAP,
    output logic                         BUSY,
    output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0]   TAP_CNT
);

    localparam int               CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TAP_W-1:0] c_max_tap = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] c_ld_tap  = TAP_W'(LOAD_TAP);

    localparam logic [1:0] c_op_load = 2'b00;
    localparam logic [1:0] c_op_inc  = 2'b01;
    localparam logic [1:0] c_op_dec  = 2'b10;
    localparam logic [1:0] c_op_set  = 2'b11;

    localparam logic [1:0] c_st_ok    = 2'b00;
    localparam logic [1:0] c_st_range = 2'b01;
    localparam logic [1:0] c_st_lane  = 2'b10;
    localparam logic [1:0] c_st_arg   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DIR_SETUP = 3'd1,
        ST_MOVE      = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CHECK     = 3'd4,
        ST_LOAD      = 3'd5,
        ST_LSETTLE   = 3'd6,
        ST_RESP      = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LANE_W-1:0]  r_lane;
    logic               r_dir;
    logic               r_dir_en;
    logic [TAP_W-1:0]   r_remain;
    logic [1:0]         r_status;
    logic [CNT_W-1:0]   r_settle;
    logic [TAP_W-1:0]   r_shadow [NUM_LANES];

    logic [NUM_LANES-1:0] w_lane_oh;
    logic [NUM_LANES-1:0] w_in_oh;
    logic [TAP_W-1:0]     w_cur_tap;
    logic [TAP_W-1:0]     w_in_tap;
    logic [TAP_W-1:0]     w_step_tap;
    logic [TAP_W-1:0]     w_steps;
    logic                 w_oor;
    logic                 w_limit;
    logic                 w_next_limit;
    logic                 w_accept;
    logic                 w_dir_nxt;
    logic [1:0]           w_status_nxt;

    // Lane decode by comparison so out-of-range lane codes select nothing.
    always_comb begin
        w_lane_oh = '0;
        w_in_oh   = '0;
        w_cur_tap = '0;
        w_in_tap  = '0;
        w_oor     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_lane_oh[i] = 1'b1;
                w_cur_tap    = r_shadow[i];
                w_oor        = DELAY_LINE_OUT_OF_RANGE[i];
            end
            if (CMD_LANE == LANE_W'(i)) begin
                w_in_oh[i] = 1'b1;
                w_in_tap   = r_shadow[i];
            end
        end
    end

    assign w_step_tap   = r_dir ? (w_cur_tap + TAP_W'(1)) : (w_cur_tap - TAP_W'(1));
    assign w_limit      = r_dir ? (w_cur_tap == c_max_tap) : (w_cur_tap == '0);
    assign w_next_limit = r_dir ? (w_step_tap == c_max_tap) : (w_step_tap == '0);

    always_comb begin
        w_next_state = r_state;
        w_status_nxt = r_status;
        w_dir_nxt    = r_dir;
        w_steps      = r_remain;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    w_accept     = 1'b1;
                    w_status_nxt = c_st_ok;
                    case (CMD_OP)
                        c_op_inc: begin
                            w_dir_nxt = 1'b1;
                            w_steps   = CMD_ARG;
                        end
                        c_op_dec: begin
                            w_dir_nxt = 1'b0;
                            w_steps   = CMD_ARG;
                        end
                        c_op_set: begin
                            w_dir_nxt = (CMD_ARG > w_in_tap);
                            w_steps   = (CMD_ARG > w_in_tap) ? (CMD_ARG - w_in_tap)
                                                             : (w_in_tap - CMD_ARG);
                        end
                        default: begin
                            w_dir_nxt = 1'b0;
                            w_steps   = '0;
                        end
                    endcase
                    if (w_in_oh == '0) begin
                        w_next_state = ST_RESP;
                        w_status_nxt = c_st_lane;
                    end else if (CMD_OP == c_op_load) begin
                        w_next_state = ST_LOAD;
                    end else if ((CMD_OP == c_op_set) && (CMD_ARG > c_max_tap)) begin
                        w_next_state = ST_RESP;
                        w_status_nxt = c_st_arg;
                    end else if (w_steps == '0) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_DIR_SETUP;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (w_limit) begin
                    w_next_state = ST_RESP;
                    w_status_nxt = c_st_range;
                end else begin
                    w_next_state = ST_MOVE;
                end
            end
            ST_MOVE:    w_next_state = ST_SETTLE;
            ST_SETTLE:  if (r_settle == '0) w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (w_oor) begin
                    w_next_state = ST_RESP;
                    w_status_nxt = c_st_range;
                end else if (r_remain == TAP_W'(1)) begin
                    w_next_state = ST_RESP;
                end else if (w_next_limit) begin
                    w_next_state = ST_RESP;
                    w_status_nxt = c_st_range;
                end else begin
                    w_next_state = ST_MOVE;
                end
            end
            ST_LOAD:    w_next_state = ST_LSETTLE;
            ST_LSETTLE: if (r_settle == '0) w_next_state = ST_RESP;
            ST_RESP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state  <= ST_IDLE;
            r_lane   <= '0;
            r_dir    <= 1'b0;
            r_dir_en <= 1'b0;
            r_remain <= '0;
            r_status <= c_st_ok;
            r_settle <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_shadow[i] <= c_ld_tap;
            end
        end else begin
            r_state  <= w_next_state;
            r_status <= w_status_nxt;
            if (w_accept) begin
                r_lane   <= CMD_LANE;
                r_dir    <= w_dir_nxt;
                r_remain <= w_steps;
            end else if ((r_state == ST_CHECK) && !w_oor) begin
                r_remain <= r_remain - TAP_W'(1);
            end
            // DIRECTION stays asserted from DIR_SETUP through the response cycle.
            if (w_next_state == ST_DIR_SETUP) begin
                r_dir_en <= 1'b1;
            end else if (r_state == ST_RESP) begin
                r_dir_en <= 1'b0;
            end
            if ((r_state == ST_MOVE) || (r_state == ST_LOAD)) begin
                r_settle <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (r_settle != '0) begin
                r_settle <= r_settle - CNT_W'(1);
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_lane_oh[i]) begin
                    if (r_state == ST_LOAD) begin
                        r_shadow[i] <= c_ld_tap;
                    end else if ((r_state == ST_CHECK) && !w_oor) begin
                        r_shadow[i] <= w_step_tap;
                    end
                end
            end
        end
    end

    assign CMD_READY            = (r_state == ST_IDLE) && !SYNC_RST;
    assign BUSY                 = (r_state != ST_IDLE);
    assign RSP_VALID            = (r_state == ST_RESP);
    assign RSP_STATUS           = RSP_VALID ? r_status : 2'b00;
    assign RSP_TAP              = RSP_VALID ? w_cur_tap : '0;
    assign DELAY_LINE_LOAD      = (r_state == ST_LOAD) ? w_lane_oh : '0;
    assign DELAY_LINE_MOVE      = (r_state == ST_MOVE) ? w_lane_oh : '0;
    assign DELAY_LINE_DIRECTION = (r_dir_en && r_dir) ? w_lane_oh : '0;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_tap_cnt
            assign TAP_CNT[gi*TAP_W +: TAP_W] = r_shadow[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ddr_ca_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_ca_delay_ctrl
// Brief    : Self-checking bench: directed vector table, reset corner cases
//            and random commands against a transaction-level tap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_ca_delay_ctrl;

    localparam int NL    = 8;
    localparam int LW    = 4;
    localparam int TW    = 8;
    localparam int MAXT  = 127;
    localparam int LT    = 1;
    localparam int S     = 4;
    localparam int P     = S + 2;
    localparam int BOUND = 2000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [LW-1:0]     cmd_lane = '0;
    logic [1:0]        cmd_op = '0;
    logic [TW-1:0]     cmd_arg = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [TW-1:0]     rsp_tap;
    logic              busy;
    logic [NL-1:0]     dl_load;
    logic [NL-1:0]     dl_move;
    logic [NL-1:0]     dl_dir;
    logic [NL-1:0]     dl_oor = '0;
    logic [NL*TW-1:0]  tap_cnt;

    always #5 clk = ~clk;

    ddr_ca_delay_ctrl #(
        .NUM_LANES(NL), .LANE_W(LW), .TAP_W(TW), .MAX_TAP(MAXT),
        .LOAD_TAP(LT), .SETTLE_CYCLES(S)
    ) dut (
        .FAB_CLK(clk), .SYNC_RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_LANE(cmd_lane), .CMD_OP(cmd_op), .CMD_ARG(cmd_arg),
        .RSP_VALID(rsp_valid), .RSP_STATUS(rsp_status), .RSP_TAP(rsp_tap),
        .BUSY(busy),
        .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move),
        .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_OUT_OF_RANGE(dl_oor),
        .TAP_CNT(tap_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_tap [NL];

    typedef struct {
        int lane;
        int op;
        int arg;
        int oor_after;
        int status;
        int tap;
        int lat;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NL-1:0] lane_oh(input int lane);
        logic [NL-1:0] v;
        v = '0;
        if (lane < NL) v[lane] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] exp_tap_cnt();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*TW +: TW] = TW'(m_tap[i]);
        return v;
    endfunction

    // Transaction-level model: outcome, latency and pulse counts of one command.
    task automatic model_cmd(input int lane, input int op, input int arg, input int oor_after,
                             output int st, output int tap, output int lat, output int moves,
                             output int dir_used, output int dir, output int load);
        int steps;
        st = 0; moves = 0; dir_used = 0; dir = 0; load = 0; tap = 0; lat = -1; steps = 0;
        if (lane >= NL) begin
            st = 2; lat = 1;
            return;
        end
        if (op == 0) begin
            m_tap[lane] = LT; load = 1; tap = LT; lat = 2 + S;
            return;
        end
        if (op == 3 && arg > MAXT) begin
            st = 3; tap = m_tap[lane]; lat = 1;
            return;
        end
        if (op == 1) begin dir = 1; steps = arg; end
        else if (op == 2) begin dir = 0; steps = arg; end
        else begin
            dir   = (arg > m_tap[lane]) ? 1 : 0;
            steps = (arg > m_tap[lane]) ? arg - m_tap[lane] : m_tap[lane] - arg;
        end
        if (steps == 0) begin
            dir = 0; tap = m_tap[lane]; lat = 1;
            return;
        end
        dir_used = 1;
        for (int k = 0; k < steps; k++) begin
            if ((dir == 1 && m_tap[lane] == MAXT) || (dir == 0 && m_tap[lane] == 0)) begin
                st = 1; lat = 2 + k * P;
                break;
            end
            moves++;
            if (moves == oor_after) begin
                st = 1; lat = 2 + (k + 1) * P;
                break;
            end
            m_tap[lane] += (dir == 1) ? 1 : -1;
        end
        if (lat < 0) lat = 2 + steps * P;
        tap = m_tap[lane];
    endtask

    task automatic run_cmd(input int lane, input int op, input int arg, input int oor_after,
                           output int lat, output int status, output int tap);
        int e_st, e_tap, e_lat, e_moves, e_dir_used, e_dir, e_load;
        int moves, bad, dir_bad, w;
        logic [NL-1:0] oh, exp_dir;
        logic exp_move, exp_load;
        model_cmd(lane, op, arg, oor_after, e_st, e_tap, e_lat, e_moves, e_dir_used, e_dir, e_load);
        oh = lane_oh(lane);
        lat = -1; status = -1; tap = -1; moves = 0; bad = 0; dir_bad = 0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        dl_oor    = NL'($urandom) & ~oh;
        cmd_valid = 1'b1;
        cmd_lane  = LW'(lane);
        cmd_op    = 2'(op);
        cmd_arg   = TW'(arg);
        @(posedge clk);
        for (int k = 1; k <= BOUND && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            exp_move = (k >= 2) && (((k - 2) % P) == 0) && (((k - 2) / P) < e_moves);
            exp_load = (e_load == 1) && (k == 1);
            exp_dir  = (e_dir_used == 1 && e_dir == 1 && k <= e_lat) ? oh : '0;
            if (dl_move !== (exp_move ? oh : '0)) bad++;
            if (dl_load !== (exp_load ? oh : '0)) bad++;
            if (dl_dir !== exp_dir) dir_bad++;
            if (lane < NL && dl_move[lane] === 1'b1) begin
                moves++;
                if (moves == oor_after) dl_oor[lane] = 1'b1;
            end
            if (rsp_valid === 1'b1) begin
                lat = k; status = int'(rsp_status); tap = int'(rsp_tap);
            end
        end
        chk($sformatf("rsp_lat(l%0d op%0d a%0d)", lane, op, arg), lat, e_lat);
        chk($sformatf("rsp_status(l%0d op%0d a%0d)", lane, op, arg), status, e_st);
        chk($sformatf("rsp_tap(l%0d op%0d a%0d)", lane, op, arg), tap, e_tap);
        chk("move_count", moves, e_moves);
        chk("pulse_timing", bad, 0);
        chk("direction_window", dir_bad, 0);
        @(negedge clk);
        dl_oor = '0;
        chk("ready_after_rsp", cmd_ready, 1);
        chk("dir_after_rsp", dl_dir, 0);
        chk("tap_cnt", tap_cnt, exp_tap_cnt());
    endtask

    initial begin
        int lat, st, tp, moves, w, rsp_seen;
        int lane, op, arg, oor_after;
        logic [63:0] all_lt;

        all_lt = '0;
        for (int i = 0; i < NL; i++) begin
            m_tap[i] = LT;
            all_lt[i*TW +: TW] = TW'(LT);
        end

        vecs[0]  = '{3, 0, 0,   0, 0, 1,   6};
        vecs[1]  = '{0, 1, 3,   0, 0, 4,   20};
        vecs[2]  = '{0, 3, 2,   0, 0, 2,   14};
        vecs[3]  = '{1, 1, 5,   2, 1, 2,   14};
        vecs[4]  = '{8, 1, 1,   0, 2, 0,   1};
        vecs[5]  = '{2, 3, 128, 0, 3, 1,   1};
        vecs[6]  = '{4, 3, 0,   0, 0, 0,   8};
        vecs[7]  = '{4, 2, 2,   0, 1, 0,   2};
        vecs[8]  = '{5, 1, 0,   0, 0, 1,   1};
        vecs[9]  = '{6, 3, 127, 0, 0, 127, 758};
        vecs[10] = '{6, 1, 1,   0, 1, 127, 2};
        vecs[11] = '{9, 0, 0,   0, 2, 0,   1};
        vecs[12] = '{0, 3, 2,   0, 0, 2,   1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready_low", cmd_ready, 0);
        chk("rst_tap_cnt", tap_cnt, all_lt);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp", {rsp_valid, rsp_status, rsp_tap}, 0);
        chk("post_rst_pulses", {dl_load, dl_move, dl_dir}, 0);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].lane, vecs[i].op, vecs[i].arg, vecs[i].oor_after, lat, st, tp);
            chk($sformatf("vec%0d_status", i), st, vecs[i].status);
            chk($sformatf("vec%0d_tap", i), tp, vecs[i].tap);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Reset during SETTLE of an INC on lane 2 (lane 2 sits at LOAD_TAP here)
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1; cmd_lane = LW'(2); cmd_op = 2'b01; cmd_arg = TW'(5);
        @(posedge clk);
        moves = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (dl_move[2] === 1'b1) moves++;
        end
        chk("midrst_moves_before", moves, 2);
        chk("midrst_dir_before", dl_dir, lane_oh(2));
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_move", dl_move, 0);
        chk("midrst_dir", dl_dir, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tap_cnt", tap_cnt, all_lt);
        rsp_seen = (rsp_valid === 1'b1) ? 1 : 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_seen = 1;
            if (dl_load !== '0) rsp_seen = 1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_rsp_or_load", rsp_seen, 0);
        chk("midrst_ready_after", cmd_ready, 1);
        for (int i = 0; i < NL; i++) m_tap[i] = LT;

        // Random commands against the model
        for (int n = 0; n < 40; n++) begin
            lane = $urandom_range(0, 9);
            op   = $urandom_range(0, 3);
            if (op == 3)
                arg = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 20);
            else
                arg = $urandom_range(0, 12);
            oor_after = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_cmd(lane, op, arg, oor_after, lat, st, tp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_ca_delay_ctrl.md
# ddr_ca_delay_ctrl

Sequencer for the delay lines of the DDR4 address/command IOD lanes (A0..A13, BA, BG, ACT_N, ...). It accepts tap-adjust commands from the training/calibration logic and emits per-lane DELAY_LINE_LOAD, MOVE and DIRECTION pulses with mandatory settle gaps. It keeps a shadow tap count per lane and reports DELAY_LINE_OUT_OF_RANGE hits. It sits between the CA-training state machine and the bank of address IOD wrappers.

## Interface
- NUM_LANES, 8, number of IOD lanes controlled
- LANE_W, 3, width of lane index (≥ clog2(NUM_LANES))
- TAP_W, 8, width of tap counts/arguments
- MAX_TAP, 127, highest legal tap
- LOAD_TAP, 1, tap value after DELAY_LINE_LOAD (matches IOD TX_DELAY_VAL)
- SETTLE_CYCLES, 4, idle cycles after every LOAD/MOVE pulse (≥1)

- FAB_CLK  in  1  fabric clock; only clock
- SYNC_RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  high in IDLE only
- CMD_LANE  in  LANE_W  target lane
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 SET (absolute)
- CMD_ARG  in  TAP_W  step count (INC/DEC) or target tap (SET); ignored for LOAD
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_STATUS  out  2  00 OK, 01 out-of-range, 10 bad lane, 11 bad arg
- RSP_TAP  out  TAP_W  lane shadow tap at completion (0 for bad lane)
- BUSY  out  1  state ≠ IDLE
- DELAY_LINE_LOAD  out  NUM_LANES  one-hot load pulse
- DELAY_LINE_MOVE  out  NUM_LANES  one-hot move pulse
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment; driven only on active lane
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  IOD range flags
- TAP_CNT  out  NUM_LANES*TAP_W  shadow taps, lane i at [i*TAP_W +: TAP_W]

## Operation
- States: IDLE, DIR_SETUP, MOVE, SETTLE, CHECK, LOAD, LSETTLE, RESP.
- Accept on CMD_VALID & CMD_READY. Lane, op and arg are latched.
- CMD_LANE ≥ NUM_LANES: go to RESP with status 10. No pulses.
- LOAD: LOAD state drives DELAY_LINE_LOAD[lane]=1 for 1 cycle and sets shadow to LOAD_TAP. Then LSETTLE for SETTLE_CYCLES, then RESP with status 00.
- INC/DEC: remaining steps = CMD_ARG.
- SET:
  - CMD_ARG > MAX_TAP: RESP with status 11.
  - Otherwise direction = (CMD_ARG > shadow) and remaining steps = |CMD_ARG − shadow|.
- Remaining steps = 0: RESP with status 00.
- DIR_SETUP: drives DIRECTION[lane] for 1 cycle before the first MOVE. DIRECTION is held until RESP ends, then returns to 0.
- Limit guard: before each MOVE, if shadow = MAX_TAP (inc) or 0 (dec), go to RESP with status 01 and issue no pulse.
- MOVE: MOVE[lane]=1 for 1 cycle, then SETTLE for SETTLE_CYCLES, then CHECK.
- CHECK samples OUT_OF_RANGE[lane]:
  - Flag high: shadow unchanged (step not counted); RESP with status 01.
  - Flag low: shadow ±1 and remaining −1. If remaining = 0, go to RESP (00); otherwise go to MOVE after the limit guard.
- RESP: RSP_VALID=1 for 1 cycle with RSP_TAP = the updated shadow; next state IDLE.
- Only one lane is ever pulsed. LOAD and MOVE are never high in the same cycle.
- CMD_VALID while busy is ignored. The requester holds it until READY.

## Timing
- Accept cycle is T. P = SETTLE_CYCLES + 2.
- INC/DEC/SET, N steps:
  - DIR_SETUP at T+1.
  - MOVE k (k=0..N−1) at T+2+k·P.
  - RSP_VALID at T+2+N·P.
- LOAD: LOAD pulse at T+1, RSP_VALID at T+2+SETTLE_CYCLES.
- Bad lane, bad arg, or zero steps: RSP_VALID at T+1.
- Limit hit before MOVE k: RSP_VALID at T+2+k·P, with no MOVE in that cycle.
- CMD_READY reasserts the cycle after RSP_VALID.
- Reset values: all outputs 0, except TAP_CNT = LOAD_TAP on every lane; state IDLE.
- SYNC_RST mid-operation:
  - Aborts on the next edge. All pulses and DIRECTION go to 0; no RSP_VALID.
  - Shadows return to LOAD_TAP.
  - No LOAD is issued; training must reissue LOAD per lane.
  - CMD_READY is high the first cycle after SYNC_RST deasserts.

## Test plan
- Reset, then LOAD lane 3 (defaults) -> LOAD[3] at T+1 only; RSP_VALID at T+6, status 00, RSP_TAP 1, TAP_CNT lane 3 = 1.
- INC lane 0 by 3 -> DIRECTION[0] high T+1..T+20; MOVE[0] at T+2, T+8, T+14; RSP at T+20, status 00, tap 4.
- Then SET lane 0 to 2 -> DIRECTION[0]=0; 2 MOVE pulses at T+2, T+8; RSP at T+14, tap 2.
- INC lane 1 by 5 from tap 1, with the bench raising OUT_OF_RANGE[1] after the 2nd MOVE -> exactly 2 MOVE pulses; RSP at T+14, status 01, tap 2.
- Error and limit responses:
  - CMD_LANE=8 -> RSP at T+1, status 10, no pulses.
  - SET arg 128 -> RSP at T+1, status 11.
  - DEC by 2 at tap 0 -> RSP at T+2, status 01, no MOVE.
- SYNC_RST asserted during SETTLE of an INC -> MOVE/DIRECTION 0 next cycle; no RSP_VALID; TAP_CNT all 1; READY high after release.
